switch_debouncer: RTL and testbench
===================================

// Module: switch_debouncer
// PURPOSE
//  Conditions the raw Basys3 slide-switch bank ahead of the combinational switch-to-LED logic.
//  Each switch gets a 2-flop synchroniser and a stability counter. The debounced level
//  sw_clean drives the downstream logic's sw[4:0] bus. One-cycle rise and fall pulses are
//  also produced for any sequential consumer.
// PARAMETERS
//  N_SW           5          number of switch inputs handled (>=1)
//  STABLE_CYCLES  1_000_000  consecutive differing samples needed to accept a change (10 ms @ 100 MHz), >=2
// PORTS
//  clk        in   1     system clock (100 MHz on board)
//  rst_n      in   1     asynchronous active-low reset
//  sw_raw     in   N_SW  raw switch pins, asynchronous to clk
//  sw_clean   out  N_SW  debounced switch levels, to downstream sw bus
//  sw_rise    out  N_SW  1-cycle pulse per bit when sw_clean goes 0->1
//  sw_fall    out  N_SW  1-cycle pulse per bit when sw_clean goes 1->0
//  any_change out  1     OR of sw_rise|sw_fall, same cycle
//  change_cnt out  8     accepted-change count (see CONFIGURATION)
// BEHAVIOUR
//  - Reset (rst_n low, async assert; release sampled on clk rising edge):
//    - sync flops, counters, sw_clean, sw_rise, sw_fall, any_change and change_cnt all go to 0.
//    - Switches already high at reset release are accepted through the normal debounce path;
//      this produces rise pulses once they are stable.
//  - Synchroniser: s1 <= sw_raw; s2 <= s1 per bit. Only s2 is used downstream of the sync flops.
//  - Per-bit counter, width $clog2(STABLE_CYCLES); all bits are independent:
//    - s2 == sw_clean: cnt <= 0. Any bounce back restarts the count.
//    - s2 != sw_clean and cnt < STABLE_CYCLES-1: cnt <= cnt+1.
//    - s2 != sw_clean and cnt == STABLE_CYCLES-1: sw_clean <= s2, cnt <= 0, and the matching
//      rise/fall bit is 1 for exactly the next cycle.
//  - Latency: sw_clean updates on the (STABLE_CYCLES+1)th clk edge after the edge that first
//    captures the new level into s1, provided sw_raw holds steady.
//  - Pulse outputs are registered. sw_rise & sw_fall is never 1 on the same bit.
//  - Several bits may change in the same cycle. Each bit gets its own pulse; any_change is 1 once.
//  - A glitch shorter than STABLE_CYCLES samples produces no output change and no pulse.
//  - Reset mid-count discards the count; there is no partial carry-over after release.
//  - Counters never wrap: cnt is cleared on acceptance, so it never exceeds STABLE_CYCLES-1.
// CONFIGURATION
//  SW_CHANGE_CNT_EN defined:
//    - change_cnt increments by 1 in each cycle where any_change is 1. This is one count per
//      cycle, not per bit.
//    - It saturates at 255 and is cleared only by reset.
//  SW_CHANGE_CNT_EN undefined:
//    - no counter logic is built; change_cnt is tied to 8'd0.
//    - all other behaviour is identical.
// TESTING (bench uses STABLE_CYCLES=4, N_SW=5)
//  1 Hold rst_n=0 with sw_raw=5'b10101, then release.
//    -> all outputs 0 during reset; sw_clean=10101 exactly 5 edges after the first s1 capture;
//       sw_rise=10101 for 1 cycle.
//  2 From all-0, set sw_raw[2]=1 and hold.
//    -> sw_clean[2]=1 on the 5th edge after capture; sw_rise=00100 and any_change=1 for 1 cycle;
//       no other bit moves.
//  3 From all-0, make sw_raw[1] high for 3 cycles, low for 1, then high for good.
//    -> no change during the glitch; sw_clean[1]=1 only 5 edges after the final rise is captured.
//  4 From sw_clean=11111, set sw_raw=00000 on one cycle.
//    -> sw_fall=11111 in a single cycle; any_change high for exactly 1 cycle.
//  5 Set sw_raw[0]=1, and assert rst_n=0 after 2 counted cycles.
//    -> outputs 0 immediately (async); after release, a full 5-edge delay before sw_clean[0]=1.
//  6 With SW_CHANGE_CNT_EN, toggle sw_raw[3] stably 260 times.
//    -> change_cnt reads 255 and stays there; rebuilt without the macro, change_cnt==0 throughout.

Source files
------------

// File: rtl/switch_debouncer.sv
// ============================================================================
// switch_debouncer: per-bit 2-flop synchroniser + stability counter for a switch bank,
// with registered rise/fall pulses. Optional macro: SW_CHANGE_CNT_EN (change counter).
// Revision: 1.0
// ============================================================================
`default_nettype none

module switch_debouncer #(
  parameter int N_SW          = 5,
  parameter int STABLE_CYCLES = 1_000_000
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N_SW-1:0] sw_raw,
  output logic [N_SW-1:0] sw_clean,
  output logic [N_SW-1:0] sw_rise,
  output logic [N_SW-1:0] sw_fall,
  output logic            any_change,
  output logic [7:0]      change_cnt
);

  localparam int                CNT_W   = $clog2(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

  logic [N_SW-1:0]            s1_q, s2_q;
  logic [N_SW-1:0]            clean_q, clean_d;
  logic [N_SW-1:0]            rise_q, rise_d;
  logic [N_SW-1:0]            fall_q, fall_d;
  logic                       any_q, any_d;
  logic [N_SW-1:0][CNT_W-1:0] cnt_q, cnt_d;

  // A bit is accepted only after CNT_MAX+1 consecutive samples that disagree with sw_clean.
  always_comb begin
    clean_d = clean_q;
    rise_d  = '0;
    fall_d  = '0;
    cnt_d   = cnt_q;
    for (int i = 0; i < N_SW; i++) begin
      if (s2_q[i] == clean_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_MAX) begin
        clean_d[i] = s2_q[i];
        cnt_d[i]   = '0;
        rise_d[i]  = s2_q[i];
        fall_d[i]  = ~s2_q[i];
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
    end
    any_d = |(rise_d | fall_d);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q    <= '0;
      s2_q    <= '0;
      clean_q <= '0;
      rise_q  <= '0;
      fall_q  <= '0;
      any_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      s1_q    <= sw_raw;
      s2_q    <= s1_q;
      clean_q <= clean_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      any_q   <= any_d;
      cnt_q   <= cnt_d;
    end
  end

  assign sw_clean   = clean_q;
  assign sw_rise    = rise_q;
  assign sw_fall    = fall_q;
  assign any_change = any_q;

`ifdef SW_CHANGE_CNT_EN
  logic [7:0] chg_q;

  // Counts pulse cycles, not bits; holds at 255 until reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chg_q <= 8'd0;
    end else if (any_q && (chg_q != 8'hFF)) begin
      chg_q <= chg_q + 8'd1;
    end
  end

  assign change_cnt = chg_q;
`else
  assign change_cnt = 8'd0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_switch_debouncer.sv
// ============================================================================
// tb_switch_debouncer: directed + random stimulus checked against a sliding-window model.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_switch_debouncer;

  localparam int N  = 5;
  localparam int SC = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [N-1:0] sw_raw = '0;
  logic [N-1:0] sw_clean, sw_rise, sw_fall;
  logic         any_change;
  logic [7:0]   change_cnt;

  int n_checks = 0;
  int n_errors = 0;

  switch_debouncer #(.N_SW(N), .STABLE_CYCLES(SC)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .sw_raw     (sw_raw),
    .sw_clean   (sw_clean),
    .sw_rise    (sw_rise),
    .sw_fall    (sw_fall),
    .any_change (any_change),
    .change_cnt (change_cnt)
  );

  always #5 clk = ~clk;

  // Model state: raw history (for the two-edge sync delay) and a window of synced samples.
  logic [N-1:0] m_clean, m_rise, m_fall;
  logic         m_any;
  logic [7:0]   m_cnt;
  logic [N-1:0] hist[$];
  logic [N-1:0] win[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_clean = '0; m_rise = '0; m_fall = '0; m_any = 1'b0; m_cnt = 8'd0;
    hist.delete();
    win.delete();
  endtask

  task automatic model_edge(input logic [N-1:0] raw);
    logic [N-1:0] s2v;
    logic [N-1:0] acc;
    logic         all_diff;
`ifdef SW_CHANGE_CNT_EN
    if (m_any && m_cnt != 8'd255) m_cnt++;
`endif
    s2v = (hist.size() >= 2) ? hist[hist.size()-2] : '0;
    hist.push_back(raw);
    if (hist.size() > 2) void'(hist.pop_front());
    win.push_back(s2v);
    if (win.size() > SC) void'(win.pop_front());
    acc = '0;
    for (int b = 0; b < N; b++) begin
      all_diff = (win.size() == SC);
      for (int j = 0; j < win.size(); j++)
        if (win[j][b] == m_clean[b]) all_diff = 1'b0;
      acc[b] = all_diff;
    end
    m_rise  = acc & ~m_clean;
    m_fall  = acc & m_clean;
    m_clean = m_clean ^ acc;
    m_any   = |acc;
  endtask

  task automatic compare_all();
    check("clean", 32'(sw_clean), 32'(m_clean));
    check("rise", 32'(sw_rise), 32'(m_rise));
    check("fall", 32'(sw_fall), 32'(m_fall));
    check("any", 32'(any_change), 32'(m_any));
    check("cnt", 32'(change_cnt), 32'(m_cnt));
  endtask

  task automatic step(input logic [N-1:0] raw);
    sw_raw = raw;
    @(posedge clk);
    if (rst_n) model_edge(raw);
    else model_reset();
    #1;
    compare_all();
  endtask

  task automatic hold(input logic [N-1:0] raw, input int cycles);
    for (int k = 0; k < cycles; k++) step(raw);
  endtask

  // Assert reset mid-cycle, confirm async clear, hold, then release before the next edge.
  task automatic do_reset(input int cycles, input logic [N-1:0] raw);
    sw_raw = raw;
    rst_n  = 1'b0;
    #1;
    model_reset();
    check("rst_async_clean", 32'(sw_clean), 32'd0);
    check("rst_async_pulses", 32'({sw_rise, sw_fall, any_change}), 32'd0);
    check("rst_async_cnt", 32'(change_cnt), 32'd0);
    hold(raw, cycles);
    rst_n = 1'b1;
  endtask

  // Edges after release until sw_clean reaches target; 0 if the bound expires.
  task automatic edges_until(input logic [N-1:0] raw, input logic [N-1:0] target,
                             output int edges, output logic [N-1:0] rise_seen);
    edges = 0;
    rise_seen = '0;
    for (int k = 1; k <= 20; k++) begin
      step(raw);
      if (sw_clean == target) begin
        edges = k;
        rise_seen = sw_rise;
        break;
      end
    end
  endtask

  int           lat;
  logic [N-1:0] rs;
  logic [N-1:0] v;

  initial begin
    model_reset();
    // 1: release with switches already high
    do_reset(3, 5'b10101);
    edges_until(5'b10101, 5'b10101, lat, rs);
    check("t1_latency", 32'(lat), 32'd6);
    check("t1_rise", 32'(rs), 32'(5'b10101));
    hold(5'b10101, 2);

    // 2: single bit rise
    hold(5'b00000, 8);
    hold(5'b00100, 8);

    // 3: glitch then stable high on bit 1
    hold(5'b00000, 8);
    hold(5'b00010, 3);
    hold(5'b00000, 1);
    hold(5'b00010, 8);

    // 4: all bits fall together
    hold(5'b11111, 8);
    hold(5'b00000, 8);

    // 5: reset in the middle of a count
    hold(5'b00001, 3);
    do_reset(2, 5'b00001);
    edges_until(5'b00001, 5'b00001, lat, rs);
    check("t5_latency", 32'(lat), 32'd6);
    check("t5_rise", 32'(rs), 32'(5'b00001));

    // random segments: glitches and stable holds mixed
    for (int s = 0; s < 300; s++) begin
      v = N'($urandom);
      hold(v, int'($urandom_range(1, 7)));
    end

    // 6: 260 stable toggles of bit 3
    hold(5'b00000, 8);
    for (int t = 0; t < 260; t++)
      hold((t % 2 == 0) ? 5'b01000 : 5'b00000, 6);
    hold(5'b00000, 8);
`ifdef SW_CHANGE_CNT_EN
    check("t6_cnt_sat", 32'(change_cnt), 32'd255);
`else
    check("t6_cnt_off", 32'(change_cnt), 32'd0);
`endif

    do_reset(2, 5'b00000);
    hold(5'b00000, 3);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
